// File: rtl/mux3_bus_arbiter.sv
// Round-robin owner arbiter driving the select of a shared 3-input mux.
// Ownership ends on done, withdrawal or hold timeout; hand-over is gapless.
module mux3_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]       state;
  logic [1:0]       last_owner;
  logic [CNT_W-1:0] hold_cnt;

  logic [1:0] a1, a2, b1, b2;
  logic [1:0] idle_pick, own_pick;
  logic       idle_hit, own_hit;
  logic       owner_req, max_hit, release_now, timeout_rel;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  assign a1 = inc3(last_owner);
  assign a2 = inc3(a1);
  assign b1 = inc3(sel);
  assign b2 = inc3(b1);

  // Idle search wraps back to the last owner; hand-over search skips it.
  always_comb begin
    idle_pick = last_owner;
    if (req[a1])      idle_pick = a1;
    else if (req[a2]) idle_pick = a2;
  end

  always_comb begin
    own_pick = b2;
    if (req[b1]) own_pick = b1;
  end

  assign idle_hit = |req;
  assign own_hit  = req[b1] | req[b2];

  always_comb begin
    owner_req = 1'b0;
    unique case (sel)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
  end

  assign max_hit     = hold_cnt == CNT_W'(MAX_HOLD - 1);
  assign release_now = done | ~owner_req | max_hit;
  assign timeout_rel = ~done & owner_req & max_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 3'b000;
      sel        <= 2'd3;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (idle_hit) begin
            state    <= OWN;
            grant    <= onehot(idle_pick);
            sel      <= idle_pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (release_now) begin
            last_owner <= sel;
            timeout    <= timeout_rel;
            hold_cnt   <= '0;
            if (own_hit) begin
              grant <= onehot(own_pick);
              sel   <= own_pick;
            end else begin
              state <= IDLE;
              grant <= 3'b000;
              sel   <= 2'd3;
              busy  <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mux3_bus_arbiter.md
Name: mux3_bus_arbiter

Overview:
- Round-robin arbiter/sequencer for a shared 32-bit, 3-input datapath mux (in0/in1/in2, 2-bit select; select 3 forces output to 32'b0).
- Grants one of three requesters ownership of the shared path and drives the mux select.
- Holds ownership until the downstream resource signals completion, the owner withdraws its request, or a hold timeout expires.
- Sits between requester units (e.g. PC update, ALU writeback, memory load) and the shared mux feeding a single consumer.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the path before forced release; legal range 2..255.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request per requester; bit i requests mux input i.
- done  input  1  transaction complete from the shared resource; valid only while busy=1.
- grant  output  3  one-hot registered grant; all zero when idle.
- sel  output  2  mux select: owner index 0/1/2, or 3 (zero output) when idle.
- busy  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: grant=3'b000, sel=2'd3, busy=0, timeout=0, internal last_owner=2 (requester 0 wins first), hold_cnt=0, state=IDLE.
- All outputs are registered. sel, grant and busy are always mutually consistent: sel=i exactly when grant[i]=1; sel=3 exactly when grant=0.
- States: IDLE, OWN.
- Priority order: last_owner+1, last_owner+2, last_owner+3, all mod 3. This is evaluated over the current req bits.
- IDLE:
  - If req≠0, grant the highest-priority requester on the next edge, go to OWN, hold_cnt=0.
  - Latency: req asserted in cycle k -> grant/sel visible in cycle k+1.
  - Otherwise remain in IDLE with outputs at their idle values.
- OWN (owner o):
  - hold_cnt increments every cycle in OWN.
  - A release condition is evaluated each cycle. Conditions in priority order:
    1. done=1.
    2. req[o]=0 (withdrawal).
    3. hold_cnt==MAX_HOLD-1 without done (timeout).
  - On release, last_owner<=o. Re-arbitration excludes o, using the new priority order.
    - If any other requester is active, the next owner is granted directly at the same edge (back-to-back, no idle gap); stay in OWN, hold_cnt=0.
    - If no other request exists, go to IDLE, sel=3.
    - The released owner may be re-granted only after one IDLE cycle, or behind others via round-robin.
  - The timeout release asserts timeout=1 in the first cycle after the release (same cycle grant changes). It is cleared next cycle.
  - done and timeout in the same cycle: done wins, no timeout pulse.
- done while in IDLE is ignored.
- A request from a non-owner does not preempt. It waits for release.
- Reset asserted mid-OWN: next edge forces all reset values; any pending timeout pulse is suppressed.
- Grant is never held for more than MAX_HOLD consecutive cycles by one owner.
- Starvation bound: a steadily asserted request is granted within 2 full ownership periods.

Test Plan:
- Single request: after reset, req=3'b001 at cycle 1, done at cycle 4.
  - Required: grant=001, sel=0, busy=1 in cycles 2-4.
  - Required: cycle 5 grant=000, sel=3, busy=0.
- Round robin: req=3'b111 held, done pulsed one cycle after each grant.
  - Required grant sequence: 001,010,100,001.
  - Required: sel follows 0,1,2,0 with no idle gap between owners.
- Timeout (MAX_HOLD=4): req=3'b010 held, done never asserted.
  - Required: grant=010 for exactly 4 cycles, then grant=000 and timeout=1 for one cycle.
  - Required: requester 1 is re-granted after one IDLE cycle.
- Withdrawal and simultaneity:
  - Case A: owner 0 drops req while req[2]=1. Required: next cycle grant=100, timeout=0.
  - Case B: done and hold_cnt==MAX_HOLD-1 in the same cycle. Required: no timeout pulse.
- Reset mid-operation: rst=1 while grant=100 and at a timeout boundary.
  - Required: next cycle grant=000, sel=3, busy=0, timeout=0.
  - Required: with req=111 afterwards, requester 0 wins first.
- Idle done: done=1 with req=0.
  - Required: outputs stay at idle values and there is no state change.
